// File: rtl/mem_arb_if.sv
// Fetch, load/store and shared-memory channels of the memory arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              ifu_resp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_we;
    logic [DATA_W-1:0] lsu_wdata;
    logic [3:0]        lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_we, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with a single outstanding transaction and a per-transaction timeout.
module mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, last_grant_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic grant_ifu, grant_lsu, accept, in_flight, timeout_hit, mem_done;
    logic resp_ifu, resp_lsu;

    // Readies are gated by rst so nothing is granted while reset is held.
    always_comb begin
        // NOTE: every signal driven here gets a default first; a branch that skipped one would infer a latch.
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == S_IDLE && !rst) begin
            if (bus.ifu_req_valid && bus.lsu_req_valid) begin
                grant_ifu = (last_grant_q == OWN_LSU);
                grant_lsu = (last_grant_q == OWN_IFU);
            end else begin
                grant_ifu = bus.ifu_req_valid;
                grant_lsu = bus.lsu_req_valid;
            end
        end
    end

    assign accept      = grant_ifu | grant_lsu;
    assign in_flight   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign timeout_hit = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT);
    assign mem_done    = (state_q == S_WAIT) && bus.mem_resp_valid;

    // A response in the final WAIT cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_REQ;
            S_REQ: begin
                if (timeout_hit)            state_d = S_RESP;
                else if (bus.mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: if (mem_done || timeout_hit) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant_lsu ? OWN_LSU : OWN_IFU;
                last_grant_q <= grant_lsu ? OWN_LSU : OWN_IFU;
                cnt_q        <= '0;
                addr_q       <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
                we_q         <= grant_lsu & bus.lsu_we;
                wdata_q      <= grant_lsu ? bus.lsu_wdata : '0;
                wmask_q      <= grant_lsu ? bus.lsu_wmask : '0;
            end else if (in_flight) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (mem_done) begin
                rdata_q <= bus.mem_rdata;
                err_q   <= 1'b0;
            end else if (in_flight && timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign resp_ifu = (state_q == S_RESP) && (owner_q == OWN_IFU);
    assign resp_lsu = (state_q == S_RESP) && (owner_q == OWN_LSU);

    assign bus.ifu_req_ready  = grant_ifu;
    assign bus.ifu_resp_valid = resp_ifu;
    assign bus.ifu_rdata      = resp_ifu ? rdata_q : '0;
    assign bus.ifu_resp_err   = resp_ifu & err_q;

    assign bus.lsu_req_ready  = grant_lsu;
    assign bus.lsu_resp_valid = resp_lsu;
    assign bus.lsu_rdata      = resp_lsu ? rdata_q : '0;
    assign bus.lsu_resp_err   = resp_lsu & err_q;

    assign bus.mem_req_valid  = (state_q == S_REQ);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_we         = we_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: transaction-level reference model compared every cycle under random
// traffic, plus directed sequences with hand-computed expectations.
module tb_mem_arb;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int TO       = 8;
    localparam int TO_SHORT = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();

    mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO_SHORT)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid = 1'b0;  bus.ifu_addr = '0;
        bus.lsu_req_valid = 1'b0;  bus.lsu_addr = '0;  bus.lsu_we = 1'b0;
        bus.lsu_wdata = '0;        bus.lsu_wmask = '0;
        bus.mem_req_ready = 1'b0;  bus.mem_resp_valid = 1'b0;  bus.mem_rdata = '0;
        bus4.ifu_req_valid = 1'b0; bus4.ifu_addr = '0;
        bus4.lsu_req_valid = 1'b0; bus4.lsu_addr = '0; bus4.lsu_we = 1'b0;
        bus4.lsu_wdata = '0;       bus4.lsu_wmask = '0;
        bus4.mem_req_ready = 1'b0; bus4.mem_resp_valid = 1'b0; bus4.mem_rdata = '0;
    endtask

    task automatic drive_random(input int p_req, input int p_rdy, input int p_resp);
        bus.ifu_req_valid  = ($urandom_range(99) < p_req);
        bus.ifu_addr       = $urandom;
        bus.lsu_req_valid  = ($urandom_range(99) < p_req);
        bus.lsu_addr       = $urandom;
        bus.lsu_we         = 1'($urandom_range(1));
        bus.lsu_wdata      = $urandom;
        bus.lsu_wmask      = 4'($urandom_range(15));
        bus.mem_req_ready  = ($urandom_range(99) < p_rdy);
        bus.mem_resp_valid = ($urandom_range(99) < p_resp);
        bus.mem_rdata      = $urandom;
    endtask

    // Reference model: one transaction record (who, what, how long, answered yet).
    logic        m_busy, m_issued, m_resp_now, m_resp_err, m_owner_lsu, m_last_lsu;
    logic [31:0] m_addr, m_wdata, m_resp_data;
    logic        m_we;
    logic [3:0]  m_wmask;
    int          m_age;
    logic        e_ifu_rdy, e_lsu_rdy;
    int          to_seen = 0;
    int          ok_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_issued = 1'b0; m_resp_now = 1'b0; m_resp_err = 1'b0;
            m_owner_lsu = 1'b0; m_last_lsu = 1'b1; m_age = 0;
            check("rst_ctrl", {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid,
                  bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_err,
                  bus.lsu_resp_err, bus.mem_we}, 64'h0);
            check("rst_rdata", {bus.ifu_rdata, bus.lsu_rdata}, 64'h0);
            check("rst_mem", {bus.mem_addr, bus.mem_wdata}, 64'h0);
            check("rst_wmask", bus.mem_wmask, 64'h0);
        end else begin
            e_ifu_rdy = 1'b0;
            e_lsu_rdy = 1'b0;
            if (!m_busy && !m_resp_now) begin
                if (bus.ifu_req_valid && bus.lsu_req_valid) begin
                    e_ifu_rdy = m_last_lsu;
                    e_lsu_rdy = !m_last_lsu;
                end else begin
                    e_ifu_rdy = bus.ifu_req_valid;
                    e_lsu_rdy = bus.lsu_req_valid;
                end
            end
            check("ready", {bus.ifu_req_ready, bus.lsu_req_ready}, {e_ifu_rdy, e_lsu_rdy});
            check("mem_req_valid", bus.mem_req_valid, m_busy && !m_issued);
            check("resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid},
                  {m_resp_now && !m_owner_lsu, m_resp_now && m_owner_lsu});
            if (m_busy && !m_issued) begin
                check("mem_addr", bus.mem_addr, m_addr);
                check("mem_wdata", bus.mem_wdata, m_wdata);
                check("mem_we_wmask", {bus.mem_we, bus.mem_wmask}, {m_we, m_wmask});
            end
            if (m_resp_now) begin
                check("resp_rdata", m_owner_lsu ? bus.lsu_rdata : bus.ifu_rdata, m_resp_data);
                check("resp_err", m_owner_lsu ? bus.lsu_resp_err : bus.ifu_resp_err, m_resp_err);
                check("other_resp_zero", m_owner_lsu ? {bus.ifu_rdata, bus.ifu_resp_err}
                                                     : {bus.lsu_rdata, bus.lsu_resp_err}, 64'h0);
            end
            if ((bus.ifu_resp_valid && bus.ifu_resp_err) || (bus.lsu_resp_valid && bus.lsu_resp_err))
                to_seen++;
            if ((bus.ifu_resp_valid && !bus.ifu_resp_err) || (bus.lsu_resp_valid && !bus.lsu_resp_err))
                ok_seen++;

            // Advance the record across the coming edge.
            if (m_resp_now) begin
                m_resp_now = 1'b0;
            end else if (!m_busy) begin
                if (e_ifu_rdy || e_lsu_rdy) begin
                    m_busy = 1'b1; m_issued = 1'b0; m_age = 0;
                    m_owner_lsu = e_lsu_rdy; m_last_lsu = e_lsu_rdy;
                    m_addr  = e_lsu_rdy ? bus.lsu_addr : bus.ifu_addr;
                    m_we    = e_lsu_rdy ? bus.lsu_we : 1'b0;
                    m_wdata = e_lsu_rdy ? bus.lsu_wdata : 32'h0;
                    m_wmask = e_lsu_rdy ? bus.lsu_wmask : 4'h0;
                end
            end else begin
                m_age++;
                if (m_issued && bus.mem_resp_valid) begin
                    m_resp_now = 1'b1; m_resp_data = bus.mem_rdata; m_resp_err = 1'b0; m_busy = 1'b0;
                end else if (m_age == TO) begin
                    m_resp_now = 1'b1; m_resp_data = 32'h0; m_resp_err = 1'b1; m_busy = 1'b0;
                end else if (!m_issued && bus.mem_req_ready) begin
                    m_issued = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "watchdog expired");
    end

    int   n_grant;
    int   both_hi;
    logic grants [4];

    initial begin
        rst = 1'b1;
        clear_inputs();
        step();
        step();

        // Everything active while reset is held: outputs must stay quiet.
        bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1;
        #1;
        check("rst_ifu_ready", bus.ifu_req_ready, 0);
        check("rst_lsu_ready", bus.lsu_req_ready, 0);
        check("rst_mem_valid", bus.mem_req_valid, 0);
        step();

        // Single fetch, zero-wait memory: response three cycles after the handshake.
        rst = 1'b0;
        bus.lsu_req_valid = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.ifu_addr = 32'h8000_0000;
        #1;
        check("fetch_ready", bus.ifu_req_ready, 1);
        step();
        bus.ifu_req_valid = 1'b0;
        #1;
        check("fetch_mem_valid", bus.mem_req_valid, 1);
        check("fetch_mem_addr", bus.mem_addr, 64'h8000_0000);
        check("fetch_mem_we", {bus.mem_we, bus.mem_wmask}, 0);
        step();
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h0010_0073;
        #1;
        check("fetch_wait_no_req", bus.mem_req_valid, 0);
        check("fetch_wait_no_resp", bus.ifu_resp_valid, 0);
        step();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("fetch_resp_valid", bus.ifu_resp_valid, 1);
        check("fetch_rdata", bus.ifu_rdata, 64'h0010_0073);
        check("fetch_err", bus.ifu_resp_err, 0);
        check("fetch_lsu_quiet", bus.lsu_resp_valid, 0);
        step();
        #1;
        check("fetch_resp_one_cycle", bus.ifu_resp_valid, 0);

        // Both requesting continuously after reset: strict alternation starting with IFU.
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1;
        n_grant = 0;
        both_hi = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.ifu_req_ready && bus.lsu_req_ready) begin
                both_hi++;
            end else if (bus.ifu_req_ready || bus.lsu_req_ready) begin
                if (n_grant < 4) grants[n_grant] = bus.lsu_req_ready;
                n_grant++;
            end
            step();
        end
        bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        check("rr_grant_count", n_grant, 4);
        check("rr_both_ready", both_hi, 0);
        for (int i = 0; i < 4; i++) check($sformatf("rr_grant_%0d_is_lsu", i), grants[i], 64'(i % 2));

        // Store with memory stalling three cycles: request must hold steady for four.
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.lsu_req_valid = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'h8000_0100;
        bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 4'hF;
        #1;
        check("store_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.lsu_req_valid = 1'b0;
            bus.mem_req_ready = (i == 3);
            #1;
            check("store_mem_valid", bus.mem_req_valid, 1);
            check("store_mem_addr", bus.mem_addr, 64'h8000_0100);
            check("store_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF);
            check("store_mem_we_wmask", {bus.mem_we, bus.mem_wmask}, 5'h1F);
        end
        step();
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        #1;
        check("store_wait_no_req", bus.mem_req_valid, 0);
        step();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("store_resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b01);
        check("store_rdata", bus.lsu_rdata, 64'h1234_5678);
        check("store_err", bus.lsu_resp_err, 0);
        step();

        // Response coinciding with mem_req_ready is ignored; the next one in WAIT completes.
        bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0040;
        #1;
        check("early_ready", bus.ifu_req_ready, 1);
        step();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        step();
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        #1;
        check("early_not_done", bus.ifu_resp_valid, 0);
        step();
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h600D_600D;
        #1;
        check("early_still_waiting", bus.ifu_resp_valid, 0);
        step();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("early_resp_valid", bus.ifu_resp_valid, 1);
        check("early_rdata", bus.ifu_rdata, 64'h600D_600D);
        step();

        // Reset pulsed in WAIT: outputs drop at once, no response afterwards, tie goes to IFU.
        bus.lsu_req_valid = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h8000_0080;
        step();
        bus.lsu_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        #1;
        check("abort_in_wait", {bus.mem_req_valid, bus.mem_addr}, {1'b0, 32'h8000_0080});
        rst = 1'b1;
        bus.ifu_req_valid = 1'b1;
        #1;
        check("abort_mem_addr", bus.mem_addr, 0);
        check("abort_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
        check("abort_resp", {bus.lsu_resp_valid, bus.lsu_rdata}, 0);
        step();
        step();
        rst = 1'b0;
        bus.ifu_req_valid = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("abort_no_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
            step();
        end
        bus.mem_resp_valid = 1'b0;
        bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
        #1;
        check("abort_tie_ifu", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10);
        step();
        bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1;
        repeat (6) step();
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;

        // Short-timeout instance: a load the memory never accepts times out after four cycles.
        bus4.lsu_req_valid = 1'b1; bus4.lsu_addr = 32'h8000_0200;
        #1;
        check("to4_ready", bus4.lsu_req_ready, 1);
        step();
        bus4.lsu_req_valid = 1'b0;
        for (int i = 1; i <= TO_SHORT; i++) begin
            #1;
            check("to4_mem_valid", bus4.mem_req_valid, 1);
            check("to4_no_early_resp", bus4.lsu_resp_valid, 0);
            step();
        end
        #1;
        check("to4_resp_valid", bus4.lsu_resp_valid, 1);
        check("to4_err", bus4.lsu_resp_err, 1);
        check("to4_rdata", bus4.lsu_rdata, 0);
        check("to4_req_dropped", bus4.mem_req_valid, 0);
        bus4.mem_resp_valid = 1'b1; bus4.mem_rdata = 32'hAAAA_5555;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            check("to4_late_ignored", {bus4.lsu_resp_valid, bus4.ifu_resp_valid}, 0);
        end
        bus4.mem_resp_valid = 1'b0;

        // Random traffic with occasional resets; some phases starve responses to force timeouts.
        for (int blk = 0; blk < 12; blk++) begin
            for (int c = 0; c < 250; c++) begin
                step();
                rst = ($urandom_range(499) == 0);
                drive_random(60, (blk % 3 == 1) ? 25 : 60, (blk % 3 == 2) ? 4 : 40);
            end
        end
        step();
        rst = 1'b0;
        clear_inputs();
        repeat (12) step();
        check("timeouts_exercised", to_seen > 0, 1);
        check("responses_exercised", ok_seen > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter ADDR_W, default 32 (`ISA_WIDTH), address width.
REQ-002 Parameter DATA_W, default 32 (`ISA_WIDTH), data width.
REQ-003 Parameter TIMEOUT, default 255, legal 1..255; max cycles a transaction may spend in REQ+WAIT.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ifu_req_valid in 1 / ifu_req_ready out 1 / ifu_addr in ADDR_W  instruction-fetch request channel.
REQ-007 ifu_resp_valid out 1 / ifu_rdata out DATA_W / ifu_resp_err out 1  fetch response.
REQ-008 lsu_req_valid in 1 / lsu_req_ready out 1 / lsu_addr in ADDR_W / lsu_we in 1 / lsu_wdata in DATA_W / lsu_wmask in 4  load/store request channel.
REQ-009 lsu_resp_valid out 1 / lsu_rdata out DATA_W / lsu_resp_err out 1  load/store response.
REQ-010 mem_req_valid out 1 / mem_req_ready in 1 / mem_addr out ADDR_W / mem_we out 1 / mem_wdata out DATA_W / mem_wmask out 4  shared memory request port.
REQ-011 mem_resp_valid in 1 / mem_rdata in DATA_W  shared memory response.

Function
REQ-012 FSM states IDLE, REQ, WAIT, RESP; one transaction outstanding at most.
REQ-013 IDLE: grant chosen combinationally; only one requester valid -> grant it; both valid -> grant the one not in last_grant (round-robin).
REQ-014 IDLE: ready asserted only to granted requester, same cycle; both readies never high together; readies 0 in all other states.
REQ-015 Handshake (valid&ready) registers addr, we, wdata, wmask, owner; updates last_grant to owner; IDLE -> REQ; timeout counter cleared.
REQ-016 IFU grants register we=0, wdata=0, wmask=0.
REQ-017 REQ: mem_req_valid=1, mem_* driven from registers, stable until mem_req_ready; on mem_req_ready -> WAIT.
REQ-018 WAIT: mem_req_valid=0; on mem_resp_valid capture mem_rdata (stores too) -> RESP.
REQ-019 mem_resp_valid outside WAIT ignored, including same cycle as mem_req_ready.
REQ-020 RESP: owner resp_valid=1 exactly one cycle, rdata=captured data; non-owner resp outputs 0; -> IDLE.
REQ-021 Timeout counter: 8-bit, increments each cycle in REQ or WAIT; no wrap (TIMEOUT<=255).
REQ-022 Counter reaching TIMEOUT without completion that cycle -> RESP with resp_err=1, rdata=0; mem_req_valid dropped.
REQ-023 Completion in the cycle count reaches TIMEOUT: success wins, err=0.
REQ-024 Late mem_resp_valid after timeout ignored.
REQ-025 Minimum latency: handshake cycle T, mem_req_valid at T+1; ready at T+1 and resp at T+2 -> resp_valid at T+3.
REQ-026 New request accepted no earlier than cycle after RESP (IDLE); no back-to-back overlap.
REQ-027 Requester dropping valid before handshake: no grant, no side effect.

Reset
REQ-028 rst high: immediately state=IDLE, counter=0, last_grant=LSU, all registered data 0.
REQ-029 During reset: all outputs 0 (readies, resp_valid, resp_err, rdata, mem_req_valid, mem_*).
REQ-030 Reset mid-transaction aborts silently; no response generated after release.
REQ-031 First tie after reset granted to IFU.

Verification
REQ-032 IFU only, addr=0x8000_0000, mem ready at once, resp 1 cycle later rdata=0x0010_0073 -> ifu_resp_valid at T+3, ifu_rdata=0x0010_0073, err=0.
REQ-033 Both valid each cycle after reset, memory zero-wait -> grants IFU, LSU, IFU, LSU alternating; never both readies high.
REQ-034 LSU store addr=0x8000_0100, wdata=0xDEAD_BEEF, wmask=0xF, mem_req_ready held low 3 cycles -> mem_* stable 4 cycles, mem_we=1, lsu_resp_valid after resp.
REQ-035 TIMEOUT=4, LSU load, memory never responds -> lsu_resp_valid with err=1, rdata=0 4 cycles after entering REQ; later mem_resp_valid ignored.
REQ-036 rst pulsed while in WAIT -> outputs 0 at once, no resp_valid after release; next tie goes to IFU.
REQ-037 mem_resp_valid asserted same cycle as mem_req_ready -> ignored; transaction completes on next mem_resp_valid in WAIT.
